// File: rtl/rc_pkt_handler.sv
// rc_pkt_handler: receive-side protocol controller, last stage of the rc chain.
// Arms rc_dpdm, waits for sync and for rc_crc's packet, classifies the packet,
// acknowledges it, retries failed receptions and reports one result per request.
// Optional statistics counters are built when RC_STATS_EN is defined.
module rc_pkt_handler #(
    parameter int SYNC_TIMEOUT = 255,
    parameter int RX_TIMEOUT   = 255,
    parameter int MAX_RETRY    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        expect_data,
    input  logic        expect_hshake,
    output logic        busy,
    output logic        receive_data,
    output logic        receive_hshake,
    output logic        abort,
    input  logic        got_sync,
    input  logic        EOP_error,
    input  logic        rc_PIDerror,
    input  logic        rc_CRCerror,
    input  logic        pkt_status,
    input  logic [7:0]  rc_hshake,
    input  logic [63:0] rc_data,
    output logic        pkt_rec,
    output logic        done,
    output logic [2:0]  result,
    output logic [63:0] data_out,
    output logic [7:0]  hshake_out,
    output logic [1:0]  retry_cnt
`ifdef RC_STATS_EN
    ,
    output logic [15:0] stat_good,
    output logic [15:0] stat_bad
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_RECV, S_CHECK, S_RETRY, S_REPORT
    } state_t;

    localparam logic [2:0] RES_ACK     = 3'b001;
    localparam logic [2:0] RES_NAK     = 3'b010;
    localparam logic [2:0] RES_STALL   = 3'b011;
    localparam logic [2:0] RES_DATA_OK = 3'b100;
    localparam logic [2:0] RES_TIMEOUT = 3'b101;
    localparam logic [2:0] RES_ERROR   = 3'b110;

    localparam logic [7:0] PID_ACK   = 8'b01001011;
    localparam logic [7:0] PID_NAK   = 8'b01011010;
    localparam logic [7:0] PID_STALL = 8'b01111000;

    localparam logic [7:0] SYNC_LIM  = 8'(SYNC_TIMEOUT - 1);
    localparam logic [7:0] RX_LIM    = 8'(RX_TIMEOUT - 1);
    localparam logic [1:0] RETRY_LIM = 2'(MAX_RETRY);

    state_t      state, next_state;
    logic        data_mode;
    logic [7:0]  timer;
    logic        eop_sticky;
    logic        rx_err;
    logic [63:0] rx_data;
    logic [7:0]  rx_hshake;
    logic [2:0]  pend_code;
    logic [2:0]  check_code;
    logic [2:0]  report_code;
    logic        accept;

    assign accept = expect_data | expect_hshake;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Next-state logic, packet classification and the code to report
    always_comb begin
        next_state  = state;
        report_code = pend_code;
        check_code  = RES_ERROR;
        if (rx_err)         check_code = RES_ERROR;
        else if (data_mode) check_code = RES_DATA_OK;
        else begin
            case (rx_hshake)
                PID_ACK:   check_code = RES_ACK;
                PID_NAK:   check_code = RES_NAK;
                PID_STALL: check_code = RES_STALL;
                default:   check_code = RES_ERROR;
            endcase
        end
        case (state)
            S_IDLE:   if (accept) next_state = S_ARM;
            S_ARM: begin
                if (got_sync)               next_state = S_RECV;
                else if (timer == SYNC_LIM) next_state = S_RETRY;
            end
            S_RECV: begin
                if (pkt_status)           next_state = S_CHECK;
                else if (timer == RX_LIM) next_state = S_RETRY;
            end
            S_CHECK: begin
                report_code = check_code;
                next_state  = (check_code == RES_ERROR) ? S_RETRY : S_REPORT;
            end
            S_RETRY:  next_state = (retry_cnt < RETRY_LIM) ? S_ARM : S_REPORT;
            S_REPORT: next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    assign busy           = (state != S_IDLE);
    assign receive_data   = data_mode  & ((state == S_ARM) | (state == S_RECV));
    assign receive_hshake = ~data_mode & ((state == S_ARM) | (state == S_RECV));
    assign abort          = (state == S_RETRY);
    assign pkt_rec        = (state == S_CHECK);
    assign done           = (state == S_REPORT);

    // Datapath: mode, timer, retry count, packet capture and reported outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            data_mode  <= 1'b0;
            timer      <= '0;
            eop_sticky <= 1'b0;
            rx_err     <= 1'b0;
            rx_data    <= '0;
            rx_hshake  <= '0;
            pend_code  <= '0;
            retry_cnt  <= '0;
            result     <= '0;
            data_out   <= '0;
            hshake_out <= '0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    data_mode <= expect_data;
                    retry_cnt <= '0;
                    timer     <= '0;
                end
                S_ARM: begin
                    if (got_sync) begin
                        timer      <= '0;
                        eop_sticky <= 1'b0;
                    end else if (timer == SYNC_LIM) begin
                        pend_code <= RES_TIMEOUT;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                S_RECV: begin
                    if (pkt_status) begin
                        rx_data   <= rc_data;
                        rx_hshake <= rc_hshake;
                        rx_err    <= rc_PIDerror | rc_CRCerror | EOP_error | eop_sticky;
                    end else begin
                        eop_sticky <= eop_sticky | EOP_error;
                        if (timer == RX_LIM) pend_code <= RES_TIMEOUT;
                        else                 timer     <= timer + 8'd1;
                    end
                end
                S_CHECK: if (check_code == RES_ERROR) pend_code <= RES_ERROR;
                S_RETRY: begin
                    timer <= '0;
                    if (retry_cnt < RETRY_LIM) retry_cnt <= retry_cnt + 2'd1;
                end
                default: ;
            endcase
            // Reported values are loaded on entry to REPORT so they are valid with done
            if (next_state == S_REPORT) begin
                result     <= report_code;
                data_out   <= rx_data;
                hshake_out <= rx_hshake;
            end
        end
    end

`ifdef RC_STATS_EN
    // Saturating good/bad reception counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_good <= '0;
            stat_bad  <= '0;
        end else begin
            if (next_state == S_RETRY && stat_bad != '1) stat_bad <= stat_bad + 16'd1;
            if (state == S_REPORT && stat_good != '1 &&
                result inside {RES_ACK, RES_NAK, RES_STALL, RES_DATA_OK})
                stat_good <= stat_good + 16'd1;
        end
    end
`endif

endmodule
